tl_sched: RTL and testbench

Timed phase scheduler for a two-road intersection with a pedestrian crossing. It sequences the A/B lamp groups through green, yellow and all-red phases, and enforces minimum and maximum green times. It shares the intersection between road A, road B and a latched pedestrian request, and grants a walk phase between road greens. It sits in the intersection top level, driven by the road traffic sensors Ta/Tb and a debounced pedestrian button, and drives the lamp drivers directly.

---
 rtl/tl_sched_if.sv | 14 +
 rtl/tl_sched.sv | 103 ++++++++++
 tb/tb_tl_sched.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tl_sched_if.sv
// Lamp/sensor bundle for the tl_sched intersection scheduler.
// The controller side drives sensors and the pedestrian request; the scheduler drives lamps.
interface tl_sched_if;
  logic       Ta;
  logic       Tb;
  logic       ped_req;
  logic [1:0] La;
  logic [1:0] Lb;
  logic       walk;
  logic [2:0] phase;

  modport master (output Ta, Tb, ped_req, input La, Lb, walk, phase);
  modport slave  (input Ta, Tb, ped_req, output La, Lb, walk, phase);
endinterface

// File: rtl/tl_sched.sv
// Timed phase scheduler for a two-road intersection with a latched pedestrian walk phase.
// Lamp outputs are registered from the next state so they track the state register exactly.
module tl_sched #(
  parameter int MIN_GREEN = 5,
  parameter int MAX_GREEN = 12,
  parameter int YELLOW    = 3,
  parameter int ALL_RED   = 1,
  parameter int WALK_T    = 4,
  parameter int CNT_W     = 4
) (
  input  logic        clk,
  input  logic        reset,
  tl_sched_if.slave   bus
);

  typedef enum logic [2:0] {
    AG   = 3'd0,
    AY   = 3'd1,
    R1   = 3'd2,
    BG   = 3'd3,
    BY   = 3'd4,
    R2   = 3'd5,
    WALK = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_C  = CNT_W'(YELLOW - 1);
  localparam logic [CNT_W-1:0] RED_C  = CNT_W'(ALL_RED - 1);
  localparam logic [CNT_W-1:0] WALK_C = CNT_W'(WALK_T - 1);

  localparam logic [1:0] LAMP_G = 2'b00;
  localparam logic [1:0] LAMP_Y = 2'b01;
  localparam logic [1:0] LAMP_R = 2'b10;

  state_t           state;
  state_t           nxt;
  logic [CNT_W-1:0] cnt;
  logic             ped_pend;
  logic             next_green;
  logic             dem_a;
  logic             dem_b;
  logic             is_green;
  logic             enter_walk;
  logic [1:0]       la_q;
  logic [1:0]       lb_q;
  logic             walk_q;

  always_comb begin
    nxt   = state;
    dem_a = bus.Ta | ped_pend;
    dem_b = bus.Tb | ped_pend;
    case (state)
      AG:   if (cnt >= MIN_C && dem_b && (!bus.Ta || cnt >= MAX_C)) nxt = AY;
      AY:   if (cnt == YEL_C) nxt = R1;
      R1:   if (cnt == RED_C) nxt = ped_pend ? WALK : BG;
      BG:   if (cnt >= MIN_C && dem_a && (!bus.Tb || cnt >= MAX_C)) nxt = BY;
      BY:   if (cnt == YEL_C) nxt = R2;
      R2:   if (cnt == RED_C) nxt = ped_pend ? WALK : AG;
      WALK: if (cnt == WALK_C) nxt = next_green ? BG : AG;
      default: nxt = AG;
    endcase
  end

  assign is_green   = (state == AG) || (state == BG);
  assign enter_walk = (nxt == WALK) && (state != WALK);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= AG;
      cnt        <= '0;
      ped_pend   <= 1'b0;
      next_green <= 1'b0;
      la_q       <= LAMP_G;
      lb_q       <= LAMP_R;
      walk_q     <= 1'b0;
    end else begin
      state <= nxt;
      if (nxt != state)
        cnt <= '0;
      else if (!(is_green && cnt == MAX_C))
        cnt <= cnt + 1'b1;

      // Entering WALK serves the pending request, so the clear beats a same-cycle ped_req.
      if (enter_walk) begin
        ped_pend   <= 1'b0;
        next_green <= (state == R1);
      end else if (bus.ped_req) begin
        ped_pend <= 1'b1;
      end

      la_q   <= (nxt == AG) ? LAMP_G : (nxt == AY) ? LAMP_Y : LAMP_R;
      lb_q   <= (nxt == BG) ? LAMP_G : (nxt == BY) ? LAMP_Y : LAMP_R;
      walk_q <= (nxt == WALK);
    end
  end

  assign bus.La    = la_q;
  assign bus.Lb    = lb_q;
  assign bus.walk  = walk_q;
  assign bus.phase = state;

endmodule

// File: tb/tb_tl_sched.sv
// Self-checking bench for tl_sched: directed phase-length scenarios plus a randomized run
// compared cycle by cycle against a phase/age reference model.
module tb_tl_sched;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  tl_sched_if bus ();

  tl_sched #(
    .MIN_GREEN (5),
    .MAX_GREEN (12),
    .YELLOW    (3),
    .ALL_RED   (1),
    .WALK_T    (4),
    .CNT_W     (4)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int P_MIN = 5, P_MAX = 12, P_YEL = 3, P_RED = 1, P_WALK = 4;

  // Reference model: current phase, cycles already spent in it, pending request, walk return.
  int m_phase;
  int m_age;
  bit m_pend;
  int m_next;

  function automatic logic [7:0] exp_out(input int p);
    case (p)
      0:       return {2'b00, 2'b10, 1'b0, 3'd0};
      1:       return {2'b01, 2'b10, 1'b0, 3'd1};
      2:       return {2'b10, 2'b10, 1'b0, 3'd2};
      3:       return {2'b10, 2'b00, 1'b0, 3'd3};
      4:       return {2'b10, 2'b01, 1'b0, 3'd4};
      5:       return {2'b10, 2'b10, 1'b0, 3'd5};
      default: return {2'b10, 2'b10, 1'b1, 3'd6};
    endcase
  endfunction

  task automatic model_step(input bit ta, input bit tb, input bit pr, input bit rs);
    int  np;
    int  held;
    bit  own;
    bit  opp;
    if (rs) begin
      m_phase = 0; m_age = 0; m_pend = 0; m_next = 0;
      return;
    end
    np   = m_phase;
    held = m_age + 1;
    case (m_phase)
      0, 3: begin
        own = (m_phase == 0) ? ta : tb;
        opp = ((m_phase == 0) ? tb : ta) | m_pend;
        if (held >= P_MIN && opp && (!own || held >= P_MAX)) np = m_phase + 1;
      end
      1, 4: if (held == P_YEL) np = m_phase + 1;
      2, 5: if (held == P_RED) np = m_pend ? 6 : ((m_phase == 2) ? 3 : 0);
      default: if (held == P_WALK) np = m_next;
    endcase
    if (np == 6 && m_phase != 6) begin
      m_next = (m_phase == 2) ? 3 : 0;
      m_pend = 0;
    end else if (pr) begin
      m_pend = 1;
    end
    m_age   = (np != m_phase) ? 0 : m_age + 1;
    m_phase = np;
  endtask

  task automatic tick(input bit ta, input bit tb, input bit pr, input bit rs);
    bus.Ta = ta; bus.Tb = tb; bus.ped_req = pr; rst = rs;
    @(posedge clk);
    model_step(ta, tb, pr, rs);
    @(negedge clk);
  endtask

  // Length of the current phase including this cycle; leaves the bench on the next phase's
  // first cycle. Returns -1 if the phase does not end within the budget.
  task automatic run_len(input bit ta, input bit tb, output int n);
    logic [2:0] p0;
    bit         done;
    p0 = bus.phase; n = 1; done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      tick(ta, tb, 1'b0, 1'b0);
      if (bus.phase != p0) done = 1;
      else n++;
    end
    if (!done) n = -1;
  endtask

  task automatic test_reset;
    bit reached;
    logic [7:0] obs;
    tick(0, 0, 0, 1);
    reached = 0;
    for (int k = 0; k < 60 && !reached; k++) begin
      tick(1, 1, 0, 0);
      if (bus.phase == 3'd4) reached = 1;
    end
    n_tests++;
    if (!reached) begin n_fail++; $display("FAIL reset_reach_by got phase %0d want 4", bus.phase); end
    tick(1, 1, 0, 1);
    tick(1, 1, 0, 1);
    obs = {bus.La, bus.Lb, bus.walk, bus.phase};
    n_tests++;
    if (obs !== 8'b00_10_0_000) begin n_fail++; $display("FAIL reset_out got %b want 00100000", obs); end
    for (int c = 0; c < 30; c++) begin
      tick(1, 0, 0, 0);
      obs = {bus.La, bus.Lb, bus.walk, bus.phase};
      n_tests++;
      if (obs !== 8'b00_10_0_000) begin n_fail++; $display("FAIL reset_hold_ag c%0d got %b want 00100000", c, obs); end
    end
  endtask

  task automatic test_b_demand;
    logic [7:0] obs;
    tick(0, 1, 0, 1);
    for (int c = 0; c <= 12; c++) begin
      obs = {bus.La, bus.Lb, bus.walk, bus.phase};
      n_tests++;
      if (obs !== exp_out(m_phase)) begin n_fail++; $display("FAIL b_demand_model c%0d got %b want %b", c, obs, exp_out(m_phase)); end
      if (c == 5 || c == 8 || c == 9) begin
        n_tests++;
        if (bus.phase !== ((c == 5) ? 3'd1 : (c == 8) ? 3'd2 : 3'd3)) begin
          n_fail++; $display("FAIL b_demand_phase c%0d got %0d", c, bus.phase);
        end
      end
      tick(0, 1, 0, 0);
    end
  endtask

  task automatic test_contention;
    int lens [6] = '{12, 3, 1, 12, 3, 1};
    int n;
    tick(1, 1, 0, 1);
    for (int i = 0; i < 6; i++) begin
      run_len(1, 1, n);
      n_tests++;
      if (n != lens[i]) begin n_fail++; $display("FAIL contention_len%0d got %0d want %0d", i, n, lens[i]); end
    end
    n_tests++;
    if (bus.phase !== 3'd0) begin n_fail++; $display("FAIL contention_back_ag got %0d want 0", bus.phase); end
  endtask

  task automatic to_walk_with_ped;
    int n;
    tick(1, 0, 0, 1);
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    tick(1, 0, 1, 0);
    run_len(1, 0, n);
    n_tests++;
    if (n + 3 != 12) begin n_fail++; $display("FAIL ped_ag_len got %0d want 12", n + 3); end
    run_len(1, 0, n);
    n_tests++;
    if (n != 3) begin n_fail++; $display("FAIL ped_ay_len got %0d want 3", n); end
    run_len(1, 0, n);
    n_tests++;
    if (n != 1) begin n_fail++; $display("FAIL ped_r1_len got %0d want 1", n); end
  endtask

  task automatic test_ped;
    int n;
    logic [7:0] obs;
    to_walk_with_ped();
    obs = {bus.La, bus.Lb, bus.walk, bus.phase};
    n_tests++;
    if (obs !== 8'b10_10_1_110) begin n_fail++; $display("FAIL ped_walk_out got %b want 10101110", obs); end
    run_len(1, 0, n);
    n_tests++;
    if (n != 4) begin n_fail++; $display("FAIL ped_walk_len got %0d want 4", n); end
    n_tests++;
    if (bus.phase !== 3'd3 || dut.ped_pend !== 1'b0) begin
      n_fail++; $display("FAIL ped_after got phase %0d pend %b want 3 0", bus.phase, dut.ped_pend);
    end
  endtask

  task automatic test_walk_req;
    int n;
    int lens [3] = '{5, 3, 1};
    to_walk_with_ped();
    tick(1, 0, 1, 0);
    n_tests++;
    if (dut.ped_pend !== 1'b1) begin n_fail++; $display("FAIL walk_req_pend got %b want 1", dut.ped_pend); end
    run_len(1, 0, n);
    n_tests++;
    if (n != 3) begin n_fail++; $display("FAIL walk_req_rest got %0d want 3", n); end
    for (int i = 0; i < 3; i++) begin
      run_len(1, 0, n);
      n_tests++;
      if (n != lens[i]) begin n_fail++; $display("FAIL walk_req_len%0d got %0d want %0d", i, n, lens[i]); end
    end
    n_tests++;
    if (bus.phase !== 3'd6 || bus.walk !== 1'b1) begin
      n_fail++; $display("FAIL walk_req_second got phase %0d walk %b want 6 1", bus.phase, bus.walk);
    end
    run_len(1, 0, n);
    n_tests++;
    if (n != 4 || bus.phase !== 3'd0) begin
      n_fail++; $display("FAIL walk_req_to_ag got len %0d phase %0d want 4 0", n, bus.phase);
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] obs;
    to_walk_with_ped();
    tick(1, 0, 1, 0);
    tick(1, 0, 0, 1);
    obs = {bus.La, bus.Lb, bus.walk, bus.phase};
    n_tests++;
    if (obs !== 8'b00_10_0_000 || dut.ped_pend !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid got %b pend %b want 00100000 0", obs, dut.ped_pend);
    end
  endtask

  task automatic test_random;
    logic [7:0] obs;
    bit ta, tb, pr, rs;
    tick(0, 0, 0, 1);
    for (int c = 0; c < 3000; c++) begin
      ta = ($urandom_range(0, 3) != 0);
      tb = ($urandom_range(0, 2) == 0);
      pr = ($urandom_range(0, 11) == 0);
      rs = ($urandom_range(0, 399) == 0);
      tick(ta, tb, pr, rs);
      obs = {bus.La, bus.Lb, bus.walk, bus.phase};
      n_tests++;
      if (obs !== exp_out(m_phase) || dut.ped_pend !== m_pend) begin
        n_fail++;
        $display("FAIL random c%0d got %b pend %b want %b pend %b", c, obs, dut.ped_pend, exp_out(m_phase), m_pend);
      end
      n_tests++;
      if (bus.La != 2'b10 && bus.Lb != 2'b10) begin
        n_fail++; $display("FAIL random_conflict c%0d got La %b Lb %b want one red", c, bus.La, bus.Lb);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.Ta = 1'b0; bus.Tb = 1'b0; bus.ped_req = 1'b0;
    test_reset();
    test_b_demand();
    test_contention();
    test_ped();
    test_walk_req();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
